// File: rtl/stream_ingress_fifo.sv
// Per-source first-word-fall-through ingress buffer for a crossbar slave port.
// Define STREAM_INGRESS_FIFO_PKT_EN for store-and-forward (head held until a whole packet is stored).
module stream_ingress_fifo #(
   parameter int unsigned T_DATA_WIDTH = 8,
   parameter int unsigned T_DEST_WIDTH = 1,
   parameter int unsigned DEPTH        = 4,
   localparam int unsigned CNT_WIDTH   = $clog2(DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [T_DATA_WIDTH-1:0] s_data_i,
   input  logic [T_DEST_WIDTH-1:0] s_dest_i,
   input  logic                    s_last_i,
   input  logic                    s_valid_i,
   output logic                    s_ready_o,
   output logic [T_DATA_WIDTH-1:0] m_data_o,
   output logic [T_DEST_WIDTH-1:0] m_dest_o,
   output logic                    m_last_o,
   output logic                    m_valid_o,
   input  logic                    m_ready_i,
   output logic [CNT_WIDTH-1:0]    count_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned EntW = T_DATA_WIDTH + T_DEST_WIDTH + 1;
   localparam logic [CNT_WIDTH-1:0] CntFull = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);
   localparam logic [PtrW-1:0]      PtrOne  = PtrW'(1);

   logic [EntW-1:0]      mem_q [DEPTH];
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic                 push, pop;
   logic                 head_vld;
   logic [EntW-1:0]      head;

   // Ready looks only at registered occupancy, so a pop never frees a slot in the same cycle.
   assign s_ready_o = ~rst & (count_q != CntFull);
   assign push      = s_valid_i & s_ready_o;
   assign pop       = m_valid_o & m_ready_i;
   assign head      = mem_q[rd_ptr_q];

`ifdef STREAM_INGRESS_FIFO_PKT_EN
   logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
   logic                 pkt_in, pkt_out;

   assign pkt_in  = push & s_last_i;
   assign pkt_out = pop & m_last_o;

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (pkt_in & ~pkt_out) begin
         pkt_cnt_d = pkt_cnt_q + CntOne;
      end else if (~pkt_in & pkt_out) begin
         pkt_cnt_d = pkt_cnt_q - CntOne;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_cnt_q <= '0;
      end else begin
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   // A full buffer with no complete packet drains cut-through so an oversize packet cannot deadlock.
   assign head_vld = (count_q != '0) & ((pkt_cnt_q != '0) | (count_q == CntFull));
`else
   assign head_vld = (count_q != '0);
`endif

   assign m_valid_o = ~rst & head_vld;
   assign count_o   = rst ? '0 : count_q;

   always_comb begin
      {m_last_o, m_dest_o, m_data_o} = '0;
      if (m_valid_o) begin
         {m_last_o, m_dest_o, m_data_o} = head;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrOne;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrOne;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CntOne;
         2'b01:   count_d = count_q - CntOne;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; stale entries are never presented because m_valid_o gates the head.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {s_last_i, s_dest_i, s_data_i};
      end
   end

endmodule
